spi_master_mc: RTL

Multi-channel, FIFO-buffered SPI master peripheral on the 8-bit CPU bus of the 6502 system. It replaces the fixed-rate per-device SPI engines (Ethernet, DAC, ADC) with one block that has these properties:
- parametrised chip-select count, FIFO depth and default SCLK rate;
- runtime-programmable divider and mode 0–3 selection;
- TX/RX FIFOs so firmware can queue multi-byte bursts under one chip select.

---
 rtl/spi_master_mc.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_mc.sv
// Multi-channel SPI master on the 8-bit CPU bus: four registers (DATA, STATUS, CTRL, CLKDIV),
// TX/RX byte FIFOs and a mode 0-3 shift engine with per-byte latched configuration.
module spi_master_mc #(
  parameter int                       FPGAClkSpeed       = 50000000,
  parameter int                       DefaultSPIClkSpeed = 10000000,
  parameter int                       address_width      = 16,
  parameter int                       data_width         = 8,
  parameter logic [address_width-1:0] BaseAddress        = 16'h9000,
  parameter int                       NumChannels        = 4,
  parameter int                       FifoDepth          = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     we_i,
  input  logic                     re_i,
  output logic [data_width-1:0]    data_o,
  output logic                     sclk_o,
  output logic                     mosi_o,
  input  logic                     miso_i,
  output logic [NumChannels-1:0]   cs_no,
  output logic                     busy_o
);

  localparam int              PtrW     = $clog2(FifoDepth);
  localparam int              DivCalc  = FPGAClkSpeed / (2 * DefaultSPIClkSpeed) - 1;
  localparam logic [7:0]      DivReset = (DivCalc < 0) ? 8'd0 : (DivCalc > 255) ? 8'd255 : 8'(DivCalc);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [PtrW:0]   CntOne   = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntFull  = (PtrW + 1)'(FifoDepth);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SETUP, ST_SHIFT, ST_END, ST_GAP} state_e;

  function automatic logic [NumChannels-1:0] cs_decode(input logic [2:0] ch);
    logic [NumChannels-1:0] res;
    for (int i = 0; i < NumChannels; i++) res[i] = (ch != 3'(i));
    return res;
  endfunction

  // Bus decode
  logic [address_width-1:0] addr_off;
  logic                     sel;
  logic [1:0]               off;
  assign addr_off = address_i - BaseAddress;
  assign sel      = (addr_off[address_width-1:2] == '0);
  assign off      = addr_off[1:0];

  // Register state
  logic [6:0]            ctrl_q, ctrl_d;
  logic [7:0]            clkdiv_q, clkdiv_d;
  logic                  tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [data_width-1:0] data_q, data_d;

  // FIFO state
  logic [7:0]      tx_mem [FifoDepth];
  logic [7:0]      rx_mem [FifoDepth];
  logic [PtrW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [PtrW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic            tx_push_req, tx_push, tx_pop, rx_pop, rx_push, rx_push_ok;
  logic [7:0]      tx_head, rx_byte, status;

  // Engine state
  state_e                 state_q, state_d;
  logic [8:0]             cnt_q, cnt_d;
  logic [4:0]             edge_cnt_q, edge_cnt_d;
  logic                   edge_q, edge_d;
  logic                   sclk_q, sclk_d, mosi_q, mosi_d;
  logic [NumChannels-1:0] cs_n_q, cs_n_d;
  logic [7:0]             tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, div_q, div_d;
  logic [2:0]             chan_q, chan_d;
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
  logic                   sample_now, shift_edge;

  assign tx_full  = (tx_cnt_q == CntFull);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CntFull);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_head  = tx_mem[tx_rd_q];
  assign busy_o   = (state_q != ST_IDLE) || !tx_empty;
  assign status   = {1'b0, rx_ovf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full, busy_o};

  // edge_q marks the cycle in which sclk_o shows edge number edge_cnt_q.
  assign sample_now = edge_q && (cpha_q ? !edge_cnt_q[0] : edge_cnt_q[0]);
  assign shift_edge = cpha_q ? !edge_cnt_q[0] : edge_cnt_q[0];
  assign rx_byte    = sample_now ? {rx_sr_q[6:0], miso_i} : rx_sr_q;
  assign rx_push    = edge_q && (edge_cnt_q == 5'd16);
  assign rx_push_ok = rx_push && !rx_full;
  assign tx_pop     = (state_q == ST_LOAD);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    edge_d     = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = sample_now ? {rx_sr_q[6:0], miso_i} : rx_sr_q;
    chan_d     = chan_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    unique case (state_q)
      ST_IDLE: if (ctrl_q[6] && !tx_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        chan_d     = ctrl_q[2:0];
        cpol_d     = ctrl_q[3];
        cpha_d     = ctrl_q[4];
        div_d      = clkdiv_q;
        cnt_d      = {1'b0, clkdiv_q};
        edge_cnt_d = '0;
        sclk_d     = ctrl_q[3];
        cs_n_d     = cs_decode(ctrl_q[2:0]);
        if (!ctrl_q[4]) begin
          mosi_d  = tx_head[7];
          tx_sr_d = {tx_head[6:0], 1'b0};
        end else begin
          tx_sr_d = tx_head;
        end
        state_d = ST_SETUP;
      end
      ST_SETUP, ST_SHIFT: begin
        if (cnt_q == 9'd0) begin
          sclk_d     = ~sclk_q;
          edge_d     = 1'b1;
          edge_cnt_d = edge_cnt_q + 5'd1;
          cnt_d      = {1'b0, div_q};
          state_d    = ST_SHIFT;
          if (shift_edge) begin
            mosi_d  = tx_sr_q[7];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
          if (edge_cnt_q == 5'd15) begin
            // END also covers the RX push cycle, hence one extra count.
            if (ctrl_q[5] && ctrl_q[6] && !tx_empty) state_d = ST_LOAD;
            else begin
              state_d = ST_END;
              cnt_d   = {1'b0, div_q} + 9'd1;
            end
          end
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      ST_END: begin
        if (cnt_q == 9'd0) begin
          state_d = ST_GAP;
          cnt_d   = {1'b0, div_q};
          cs_n_d  = '1;
        end else cnt_d = cnt_q - 9'd1;
      end
      ST_GAP: begin
        if (cnt_q == 9'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 9'd1;
      end
    endcase
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    clkdiv_d    = clkdiv_q;
    tx_ovf_d    = tx_ovf_q;
    rx_ovf_d    = rx_ovf_q;
    data_d      = '0;
    tx_push_req = we_i && sel && (off == 2'd0);
    tx_push     = tx_push_req && !tx_full;
    rx_pop      = re_i && sel && (off == 2'd0) && !rx_empty;
    if (we_i && sel && off == 2'd1) begin
      if (data_i[5]) tx_ovf_d = 1'b0;
      if (data_i[6]) rx_ovf_d = 1'b0;
    end
    if (we_i && sel && off == 2'd2) ctrl_d   = data_i[6:0];
    if (we_i && sel && off == 2'd3) clkdiv_d = data_i;
    if (tx_push_req && tx_full) tx_ovf_d = 1'b1;
    if (rx_push && rx_full)     rx_ovf_d = 1'b1;
    if (re_i && sel) begin
      unique case (off)
        2'd0: data_d = rx_empty ? 8'h00 : rx_mem[rx_rd_q];
        2'd1: data_d = status;
        2'd2: data_d = {1'b0, ctrl_q};
        2'd3: data_d = clkdiv_q;
      endcase
    end
    tx_wr_d  = tx_push    ? tx_wr_q + PtrOne : tx_wr_q;
    tx_rd_d  = tx_pop     ? tx_rd_q + PtrOne : tx_rd_q;
    rx_wr_d  = rx_push_ok ? rx_wr_q + PtrOne : rx_wr_q;
    rx_rd_d  = rx_pop     ? rx_rd_q + PtrOne : rx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CntOne;
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CntOne;
    rx_cnt_d = rx_cnt_q;
    if (rx_push_ok && !rx_pop) rx_cnt_d = rx_cnt_q + CntOne;
    if (!rx_push_ok && rx_pop) rx_cnt_d = rx_cnt_q - CntOne;
  end

  // NOTE: FIFO storage has no reset; the pointers and counts alone define its contents.
  always_ff @(posedge clk_i) begin
    if (tx_push)    tx_mem[tx_wr_q] <= data_i;
    if (rx_push_ok) rx_mem[rx_wr_q] <= rx_byte;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ctrl_q     <= '0;
      clkdiv_q   <= DivReset;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      data_q     <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      edge_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      chan_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= DivReset;
    end else begin
      ctrl_q     <= ctrl_d;
      clkdiv_q   <= clkdiv_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      data_q     <= data_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      chan_q     <= chan_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
    end
  end

  assign data_o = data_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign cs_no  = cs_n_q;

endmodule
